// File: rtl/multi_clock_divider.sv
// multi_clock_divider: CH independent runtime-programmable clock dividers from one clock.
// Each channel emits a one-cycle tick per period and a registered near-50% square wave.
// Optional macro CLKDIV_SYNC_EN adds a sync_restart input that phase-aligns enabled channels.
module multi_clock_divider #(
  parameter int unsigned    CH          = 4,
  parameter int unsigned    W           = 32,
  parameter logic [W-1:0]   DEFAULT_DIV = W'(50000000),
  parameter int unsigned    SELW        = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic            cin,
  input  logic            resetn,
  input  logic [CH-1:0]   en,
  input  logic            div_wr,
  input  logic [SELW-1:0] div_sel,
  input  logic [W-1:0]    div_val,
`ifdef CLKDIV_SYNC_EN
  input  logic            sync_restart,
`endif
  output logic [CH-1:0]   tick,
  output logic [CH-1:0]   cout
);

  localparam logic [W-1:0] TWO   = W'(2);
  // Periods below 2 cannot produce a tick and a square wave, so clamp them.
  localparam logic [W-1:0] DEF_N = (DEFAULT_DIV < TWO) ? TWO : DEFAULT_DIV;

  logic [W-1:0]  cnt_q    [CH];
  logic [W-1:0]  cnt_d    [CH];
  logic [W-1:0]  period_q [CH];
  logic [W-1:0]  period_d [CH];
  logic [W-1:0]  pend_q   [CH];
  logic [W-1:0]  pend_d   [CH];
  logic [W-1:0]  pend_eff [CH];
  logic [W-1:0]  cnt_inc  [CH];
  logic [CH-1:0] pend_valid_q, pend_valid_d, pend_eff_valid;
  logic [CH-1:0] tick_q, tick_d, cout_q, cout_d;
  logic [CH-1:0] wr_hit, wrap;
  logic [W-1:0]  div_clamped;
  logic [31:0]   sel_ext;
  logic          restart;

`ifdef CLKDIV_SYNC_EN
  assign restart = sync_restart;
`else
  assign restart = 1'b0;
`endif

  assign div_clamped = (div_val < TWO) ? TWO : div_val;
  assign sel_ext     = 32'(div_sel);

  // Per-channel decode: write hit, effective pending value (write-through), wrap and increment.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      // Out-of-range selects never match any channel, so such writes are dropped.
      wr_hit[i]         = div_wr && (sel_ext == $unsigned(i));
      pend_eff[i]       = wr_hit[i] ? div_clamped : pend_q[i];
      pend_eff_valid[i] = wr_hit[i] | pend_valid_q[i];
      wrap[i]           = (cnt_q[i] == period_q[i] - W'(1));
      cnt_inc[i]        = wrap[i] ? '0 : cnt_q[i] + W'(1);
    end
  end

  // Next-state: count while enabled, clear while idle or restarting, apply pending at safe points.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      cnt_d[i]        = '0;
      tick_d[i]       = 1'b0;
      cout_d[i]       = 1'b0;
      period_d[i]     = period_q[i];
      pend_d[i]       = pend_eff[i];
      pend_valid_d[i] = pend_eff_valid[i];
      if (en[i] && !restart) begin
        cnt_d[i]  = cnt_inc[i];
        tick_d[i] = wrap[i];
        // High for the last floor(N/2) counts, so it falls together with tick.
        cout_d[i] = (cnt_inc[i] >= (period_q[i] - (period_q[i] >> 1)));
      end
      // Only swap the period between periods so the running one always completes.
      if (pend_eff_valid[i] && (!en[i] || restart || wrap[i])) begin
        period_d[i]     = pend_eff[i];
        pend_valid_d[i] = 1'b0;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge cin or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < CH; i++) begin
        cnt_q[i]    <= '0;
        period_q[i] <= DEF_N;
        pend_q[i]   <= '0;
      end
      pend_valid_q <= '0;
      tick_q       <= '0;
      cout_q       <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        cnt_q[i]    <= cnt_d[i];
        period_q[i] <= period_d[i];
        pend_q[i]   <= pend_d[i];
      end
      pend_valid_q <= pend_valid_d;
      tick_q       <= tick_d;
      cout_q       <= cout_d;
    end
  end

  assign tick = tick_q;
  assign cout = cout_q;

endmodule
